wb_trace_fifo: RTL and testbench
================================

Name: wb_trace_fifo

Overview:
- Synthesizable commit-trace collector downstream of Simple_Single_CPU.
- Captures every architectural register-file write (address, data, PC) into a FIFO.
- Presents captured writes to a consumer (bench logger or debug UART) over a valid/ready port.
- Replaces per-cycle register dumps with an ordered, lossless-or-flagged write log.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- SEQ_W, 16, width of the per-write sequence number.
- DROP_W, 8, width of the saturating dropped-write counter.
- FILTER_R0, 1, 1 = writes targeting r0 are ignored (never captured, never counted).

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- wr_en_i  in  1  register-file write strobe (RegWrite qualified).
- wr_addr_i  in  5  destination register.
- wr_data_i  in  32  write data.
- pc_i  in  32  PC of the committing instruction.
- trace_valid_o  out  1  head entry available.
- trace_ready_i  in  1  consumer accepts the head entry.
- trace_addr_o  out  5  head entry register.
- trace_data_o  out  32  head entry data.
- trace_pc_o  out  32  head entry PC.
- trace_seq_o  out  SEQ_W  head entry sequence number.
- level_o  out  $clog2(DEPTH)+1  current occupancy.
- overflow_o  out  1  sticky: at least one write dropped.
- drop_cnt_o  out  DROP_W  dropped writes, saturating.

Behaviour:
- Reset (synchronous, active-high) clears all state: FIFO empty, trace_valid_o=0, level_o=0, overflow_o=0, drop_cnt_o=0, sequence counter=0.
  - trace_* data outputs drive 0 while empty.
  - Reset asserted mid-stream discards all entries on that edge.
- Capture condition: wr_en_i=1 and not (FILTER_R0=1 and wr_addr_i=0).
- Push:
  - An accepted capture writes {addr, data, pc, seq} at the tail.
  - The sequence counter increments by 1 and wraps modulo 2^SEQ_W.
- First-word-fall-through output:
  - A capture into an empty FIFO shows on the trace_* outputs the cycle after the capturing edge.
  - Push-to-valid latency is 1 cycle.
- Pop: a handshake completes on an edge where trace_valid_o=1 and trace_ready_i=1. The head advances, and the next entry is visible the following cycle with no bubble.
- Output stability: while trace_valid_o=1 and trace_ready_i=0, all trace_* outputs hold stable.
- Simultaneous push and pop:
  - Non-full and non-empty: level unchanged.
  - Empty: the push is accepted and valid rises next cycle; no pop occurs.
  - Full: the pop frees a slot in the same edge, so the push is accepted and nothing is dropped.
- Overflow: a capture while full without a same-edge pop is dropped.
  - overflow_o sets and stays set until reset.
  - drop_cnt_o increments, saturating at all-ones.
  - The sequence counter still increments, so the consumer sees a seq gap equal to the number of drops (mod 2^SEQ_W).
- Pointers: read and write pointers have log2(DEPTH)+1 bits.
  - Full = equal index bits with MSBs differing.
  - Empty = pointers equal.
  - level_o = wptr - rptr.
- State: single-level FIFO control, no explicit FSM beyond the EMPTY / PARTIAL / FULL conditions derived from the pointers.

Optional Feature:
- Macro: WB_TRACE_CYCLE_STAMP_EN.
- Defined:
  - Adds a free-running 32-bit cycle counter, reset to 0, incrementing every cycle and wrapping.
  - Each entry stores the counter value at its capture edge.
  - Adds output port trace_cyc_o (out, 32), with the same stability and reset-to-0 rules as the other trace_* outputs.
- Undefined: no counter, no port, entries exclude the stamp field.

Decomposition:
- Shared package wb_trace_pkg holds:
  - the entry struct typedef (addr, data, pc, seq, optional cyc);
  - the REG_ADDR_W=5, XLEN=32 constants.
- One sub-module: wb_trace_fifo_core, a generic synchronous FWFT FIFO parameterized by width/depth that holds pointers, storage and level.
- The top module handles capture filtering, the sequence counter, drop accounting and the optional stamp.

Test Plan:
- Reset then idle 5 cycles -> trace_valid_o=0, level_o=0, overflow_o=0, drop_cnt_o=0.
- Single write r1=0x0000000A at pc=0x4, trace_ready_i=1 -> valid for exactly 1 cycle next cycle with addr=1, data=0xA, pc=0x4, seq=0; level returns to 0.
- Write r0=0x55 with FILTER_R0=1 -> no entry, seq unchanged. Next write r2=7 -> seq=0.
- trace_ready_i=0, 18 consecutive writes at DEPTH=16 -> level_o=16, overflow_o=1, drop_cnt_o=2. Draining yields seq 0..15; the next accepted write carries seq 18.
- Full FIFO, push and pop on the same edge -> level stays 16, drop_cnt_o unchanged, popped seq=0, new entry accepted.
- trace_ready_i toggling 1/0 every cycle while writes arrive every cycle (DEPTH=16, 12 writes) -> outputs stable while stalled, all 12 entries delivered in order, no drops. Reset mid-stream -> next cycle level_o=0 and valid=0.

Source files
------------

// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the register-write trace collector.
// Optional feature macro: WB_TRACE_CYCLE_STAMP_EN (adds a 32-bit cycle stamp per entry).
package wb_trace_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    // Fixed-width part of a trace entry. The sequence number has a
    // parameterised width, so the top module appends it beside this struct.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
        logic [XLEN-1:0]       pc;
`ifdef WB_TRACE_CYCLE_STAMP_EN
        logic [XLEN-1:0]       cyc;
`endif
    } trace_entry_t;

    // A write is logged unless it targets r0 while r0 filtering is on.
    function automatic logic is_capture(input logic                  wr_en,
                                        input logic [REG_ADDR_W-1:0] wr_addr,
                                        input logic                  filter_r0);
        return wr_en && !(filter_r0 && (wr_addr == '0));
    endfunction

endpackage

// File: rtl/wb_trace_fifo_if.sv
// Bus bundle for the trace collector: register-file write side plus the
// valid/ready trace output and status. Optional macro: WB_TRACE_CYCLE_STAMP_EN.
interface wb_trace_fifo_if #(
    parameter int DEPTH  = 16,
    parameter int SEQ_W  = 16,
    parameter int DROP_W = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                                wr_en_i;
    logic [wb_trace_pkg::REG_ADDR_W-1:0] wr_addr_i;
    logic [wb_trace_pkg::XLEN-1:0]       wr_data_i;
    logic [wb_trace_pkg::XLEN-1:0]       pc_i;
    logic                                trace_valid_o;
    logic                                trace_ready_i;
    logic [wb_trace_pkg::REG_ADDR_W-1:0] trace_addr_o;
    logic [wb_trace_pkg::XLEN-1:0]       trace_data_o;
    logic [wb_trace_pkg::XLEN-1:0]       trace_pc_o;
    logic [SEQ_W-1:0]                    trace_seq_o;
    logic [LVL_W-1:0]                    level_o;
    logic                                overflow_o;
    logic [DROP_W-1:0]                   drop_cnt_o;
`ifdef WB_TRACE_CYCLE_STAMP_EN
    logic [wb_trace_pkg::XLEN-1:0]       trace_cyc_o;
`endif

    // Producer/consumer side (CPU write port and trace consumer).
    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, pc_i, trace_ready_i,
        input  trace_valid_o, trace_addr_o, trace_data_o, trace_pc_o,
        input  trace_seq_o, level_o, overflow_o, drop_cnt_o
`ifdef WB_TRACE_CYCLE_STAMP_EN
        , input trace_cyc_o
`endif
    );

    // Trace collector side.
    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, pc_i, trace_ready_i,
        output trace_valid_o, trace_addr_o, trace_data_o, trace_pc_o,
        output trace_seq_o, level_o, overflow_o, drop_cnt_o
`ifdef WB_TRACE_CYCLE_STAMP_EN
        , output trace_cyc_o
`endif
    );

endinterface

// File: rtl/wb_trace_fifo_core.sv
// Generic synchronous first-word-fall-through FIFO. Pointers carry one extra
// wrap bit so full and empty are distinguishable; read data is zero when empty.
module wb_trace_fifo_core #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic                     full,
    output logic                     push_ok,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             empty;
    logic             pop_ok;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop_ok);
    assign valid   = !empty;
    assign level   = wptr - rptr;
    assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

    // Storage write at the tail; data carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    // Pointer advance on accepted push/pop, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/wb_trace_fifo.sv
// Commit-trace collector: filters register-file writes, tags each with a
// sequence number, buffers them in an FWFT FIFO and accounts for drops.
// Optional macro: WB_TRACE_CYCLE_STAMP_EN adds a cycle stamp and trace_cyc_o.
module wb_trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int SEQ_W     = 16,
    parameter int DROP_W    = 8,
    parameter int FILTER_R0 = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    wb_trace_fifo_if.slave  bus
);
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = $bits(trace_entry_t) + SEQ_W;

    trace_entry_t        entry_in;
    trace_entry_t        entry_out;
    logic [SEQ_W-1:0]    seq;
    logic [SEQ_W-1:0]    seq_out;
    logic [ENTRY_W-1:0]  wdata;
    logic [ENTRY_W-1:0]  rdata;
    logic                capture;
    logic                head_valid;
    logic                fifo_full;
    logic                push_ok;
    logic                pop;
    logic                drop;
    logic [LVL_W-1:0]    level;
    logic                overflow;
    logic [DROP_W-1:0]   drop_cnt;
`ifdef WB_TRACE_CYCLE_STAMP_EN
    logic [XLEN-1:0]     cyc_cnt;
`endif

    assign capture = is_capture(bus.wr_en_i, bus.wr_addr_i, FILTER_R0 != 0);

    // Assemble the entry written at the tail.
    always_comb begin
        entry_in      = '0;
        entry_in.addr = bus.wr_addr_i;
        entry_in.data = bus.wr_data_i;
        entry_in.pc   = bus.pc_i;
`ifdef WB_TRACE_CYCLE_STAMP_EN
        entry_in.cyc  = cyc_cnt;
`endif
    end

    assign wdata                = {entry_in, seq};
    assign {entry_out, seq_out} = rdata;
    assign pop                  = head_valid && bus.trace_ready_i;
    assign drop                 = capture && !push_ok;

    wb_trace_fifo_core #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_core (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (capture),
        .wdata   (wdata),
        .pop     (pop),
        .rdata   (rdata),
        .valid   (head_valid),
        .full    (fifo_full),
        .push_ok (push_ok),
        .level   (level)
    );

    // Sequence number advances on every capture, dropped or not, so drops
    // appear to the consumer as gaps.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seq <= '0;
        end else if (capture) begin
            seq <= seq + 1'b1;
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

`ifdef WB_TRACE_CYCLE_STAMP_EN
    // Free-running cycle counter used to stamp captures.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
        end
    end

    assign bus.trace_cyc_o = entry_out.cyc;
`endif

    // fifo_full is only needed internally for push acceptance inside the core.
    logic unused_full;
    assign unused_full = fifo_full;

    assign bus.trace_valid_o = head_valid;
    assign bus.trace_addr_o  = entry_out.addr;
    assign bus.trace_data_o  = entry_out.data;
    assign bus.trace_pc_o    = entry_out.pc;
    assign bus.trace_seq_o   = seq_out;
    assign bus.level_o       = level;
    assign bus.overflow_o    = overflow;
    assign bus.drop_cnt_o    = drop_cnt;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo with a reference queue of expected entries.
module tb_wb_trace_fifo;
    localparam int DEPTH  = 16;
    localparam int SEQ_W  = 16;
    localparam int DROP_W = 8;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
        logic [15:0] seq;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    exp_t        q[$];
    logic [15:0] m_seq;
    logic [31:0] m_cyc;
    logic        m_ovf;
    logic [7:0]  m_drop;
    logic        stall_prev;
    exp_t        held;

    always #5 clk = ~clk;

    wb_trace_fifo_if #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .DROP_W(DROP_W)) bus ();

    wb_trace_fifo #(
        .DEPTH(DEPTH), .SEQ_W(SEQ_W), .DROP_W(DROP_W), .FILTER_R0(1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("valid", bus.trace_valid_o, q.size() != 0);
        chk("level", bus.level_o, q.size());
        chk("overflow", bus.overflow_o, m_ovf);
        chk("drop_cnt", bus.drop_cnt_o, m_drop);
        if (q.size() != 0) begin
            chk("head_addr", bus.trace_addr_o, q[0].addr);
            chk("head_data", bus.trace_data_o, q[0].data);
            chk("head_pc", bus.trace_pc_o, q[0].pc);
            chk("head_seq", bus.trace_seq_o, q[0].seq);
`ifdef WB_TRACE_CYCLE_STAMP_EN
            chk("head_cyc", bus.trace_cyc_o, q[0].cyc);
`endif
        end else begin
            chk("empty_addr", bus.trace_addr_o, 0);
            chk("empty_data", bus.trace_data_o, 0);
            chk("empty_pc", bus.trace_pc_o, 0);
            chk("empty_seq", bus.trace_seq_o, 0);
`ifdef WB_TRACE_CYCLE_STAMP_EN
            chk("empty_cyc", bus.trace_cyc_o, 0);
`endif
        end
    endtask

    // One clock cycle: drive inputs, check at negedge, advance the model, step past posedge.
    task automatic step(input logic we, input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] p, input logic rdy);
        exp_t e;
        bus.wr_en_i       = we;
        bus.wr_addr_i     = a;
        bus.wr_data_i     = d;
        bus.pc_i          = p;
        bus.trace_ready_i = rdy;
        @(negedge clk);
        check_outputs();
        if (stall_prev) begin
            chk("hold_addr", bus.trace_addr_o, held.addr);
            chk("hold_data", bus.trace_data_o, held.data);
            chk("hold_pc", bus.trace_pc_o, held.pc);
            chk("hold_seq", bus.trace_seq_o, held.seq);
        end
        stall_prev = bus.trace_valid_o && !rdy;
        held.addr  = bus.trace_addr_o;
        held.data  = bus.trace_data_o;
        held.pc    = bus.trace_pc_o;
        held.seq   = bus.trace_seq_o;
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (we && a != 5'd0) begin
            if (q.size() < DEPTH) begin
                e.addr = a; e.data = d; e.pc = p; e.seq = m_seq; e.cyc = m_cyc;
                q.push_back(e);
            end else begin
                m_ovf = 1'b1;
                if (m_drop != 8'hFF) m_drop++;
            end
            m_seq++;
        end
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.wr_en_i       = 1'b0;
        bus.trace_ready_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_seq = '0; m_cyc = '0; m_ovf = 1'b0; m_drop = '0; stall_prev = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en_i = 1'b0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
        bus.pc_i = '0; bus.trace_ready_i = 1'b0;

        // Reset then idle.
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        chk("rst_valid", bus.trace_valid_o, 0);
        chk("rst_level", bus.level_o, 0);
        chk("rst_overflow", bus.overflow_o, 0);
        chk("rst_drop", bus.drop_cnt_o, 0);

        // Single write, consumer ready.
        step(1, 5'd1, 32'h0000_000A, 32'h4, 1);
        chk("single_valid", bus.trace_valid_o, 1);
        chk("single_addr", bus.trace_addr_o, 1);
        chk("single_data", bus.trace_data_o, 32'hA);
        chk("single_pc", bus.trace_pc_o, 32'h4);
        chk("single_seq", bus.trace_seq_o, 0);
        step(0, 0, 0, 0, 1);
        chk("single_gone_valid", bus.trace_valid_o, 0);
        chk("single_gone_level", bus.level_o, 0);

        // r0 filtering.
        do_reset();
        step(1, 5'd0, 32'h55, 32'h8, 1);
        chk("r0_valid", bus.trace_valid_o, 0);
        step(1, 5'd2, 32'h7, 32'hC, 1);
        chk("r2_seq", bus.trace_seq_o, 0);
        chk("r2_data", bus.trace_data_o, 32'h7);
        step(0, 0, 0, 0, 1);

        // Overflow: 18 writes into a 16-deep FIFO with the consumer stalled.
        do_reset();
        for (int i = 0; i < 18; i++) step(1, 5'(i + 1), 32'h100 + i, 32'h1000 + 4 * i, 0);
        chk("ovf_level", bus.level_o, 16);
        chk("ovf_flag", bus.overflow_o, 1);
        chk("ovf_drop", bus.drop_cnt_o, 2);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1);
        chk("ovf_drained", bus.level_o, 0);
        step(1, 5'd3, 32'hBEEF, 32'h2000, 0);
        chk("ovf_gap_seq", bus.trace_seq_o, 18);
        chk("ovf_sticky", bus.overflow_o, 1);
        step(0, 0, 0, 0, 1);

        // Full FIFO: push and pop on the same edge.
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 5'(i + 1), 32'h200 + i, 32'h3000 + 4 * i, 0);
        chk("full_level", bus.level_o, 16);
        chk("full_head_seq", bus.trace_seq_o, 0);
        step(1, 5'd20, 32'hCAFE, 32'h4000, 1);
        chk("pp_level", bus.level_o, 16);
        chk("pp_drop", bus.drop_cnt_o, 0);
        chk("pp_next_seq", bus.trace_seq_o, 1);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1);
        chk("pp_drained", bus.level_o, 0);

        // Toggling ready with a write every cycle.
        do_reset();
        for (int i = 0; i < 12; i++)
            step(1, 5'(i + 4), 32'hA000 + i, 32'h5000 + 4 * i, (i % 2) == 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, (i % 2) == 1);
        chk("tog_level", bus.level_o, 0);
        chk("tog_drop", bus.drop_cnt_o, 0);
        chk("tog_seq_next", m_seq, 12);

        // Reset in the middle of a stream.
        for (int i = 0; i < 5; i++) step(1, 5'(i + 1), 32'hD00 + i, 32'h6000 + 4 * i, 0);
        chk("mid_level_before", bus.level_o, 5);
        do_reset();
        chk("mid_rst_level", bus.level_o, 0);
        chk("mid_rst_valid", bus.trace_valid_o, 0);
        step(0, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
